// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: streams one aligned block from in-order, fixed-latency
// memory into the data array, writing the tag alongside the final word.
module cache_fill_fsm #(
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WORDS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  output logic                  fsm_busy,
  output logic                  write_data_array,
  output logic                  write_tag_array,
  output logic [ADDR_WIDTH-1:0] data_addr,
  output logic [15:0]           data_out,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_data_valid,
  input  logic [15:0]           mem_data_in
);

  localparam int CW = $clog2(BLOCK_WORDS) + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_FILL = 1'b1;

  localparam logic [CW-1:0]         CNT_FULL = CW'(BLOCK_WORDS);
  localparam logic [CW-1:0]         CNT_LAST = CW'(BLOCK_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((1 << CW) - 1);

  logic [0:0]            state_q,   state_d;
  logic [ADDR_WIDTH-1:0] base_q,    base_d;
  logic [CW-1:0]         req_cnt_q, req_cnt_d;
  logic [CW-1:0]         rcv_cnt_q, rcv_cnt_d;

  logic                  fill;
  logic                  req_fire;
  logic                  rcv_fire;
  logic                  rcv_last;
  logic [ADDR_WIDTH-1:0] req_off;
  logic [ADDR_WIDTH-1:0] rcv_off;

  assign fill     = (state_q == S_FILL);
  assign req_fire = fill && (req_cnt_q < CNT_FULL);
  assign rcv_fire = fill && mem_data_valid;
  assign rcv_last = rcv_fire && (rcv_cnt_q == CNT_LAST);

  // Base is block-aligned, so OR-ing in the word offset never carries out of the block.
  assign req_off = ADDR_WIDTH'({req_cnt_q[CW-2:0], 1'b0});
  assign rcv_off = ADDR_WIDTH'({rcv_cnt_q[CW-2:0], 1'b0});

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    req_cnt_d = req_cnt_q;
    rcv_cnt_d = rcv_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (miss_detected) begin
          state_d   = S_FILL;
          base_d    = miss_address & ~OFF_MASK;
          req_cnt_d = '0;
          rcv_cnt_d = '0;
        end
      end
      S_FILL: begin
        if (req_fire) req_cnt_d = req_cnt_q + 1'b1;
        if (rcv_fire) rcv_cnt_d = rcv_cnt_q + 1'b1;
        if (rcv_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      req_cnt_q <= '0;
      rcv_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      req_cnt_q <= req_cnt_d;
      rcv_cnt_q <= rcv_cnt_d;
    end
  end

  // Everything is gated by FILL so an idle engine presents all-zero outputs.
  always_comb begin
    fsm_busy         = fill;
    mem_en           = req_fire;
    mem_addr         = fill ? (base_q | req_off) : '0;
    write_data_array = rcv_fire;
    write_tag_array  = rcv_last;
    data_addr        = rcv_fire ? (base_q | rcv_off) : '0;
    data_out         = fill ? mem_data_in : '0;
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: fills at several latencies, back-to-back
// misses, top-of-memory block, reset abort and spurious inputs.
module tb_cache_fill_fsm;

  localparam int BW = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        fsm_busy;
  logic        write_data_array;
  logic        write_tag_array;
  logic [15:0] data_addr;
  logic [15:0] data_out;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic        mem_data_valid;
  logic [15:0] mem_data_in;

  int n_vec = 0;
  int n_err = 0;

  cache_fill_fsm #(.ADDR_WIDTH(16), .BLOCK_WORDS(BW)) dut (
    .clk              (clk),
    .rst              (rst),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .fsm_busy         (fsm_busy),
    .write_data_array (write_data_array),
    .write_tag_array  (write_tag_array),
    .data_addr        (data_addr),
    .data_out         (data_out),
    .mem_en           (mem_en),
    .mem_addr         (mem_addr),
    .mem_data_valid   (mem_data_valid),
    .mem_data_in      (mem_data_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"}, 32'(fsm_busy), 32'd0);
    chk({tag, ".mem_en"}, 32'(mem_en), 32'd0);
    chk({tag, ".wr_data"}, 32'(write_data_array), 32'd0);
    chk({tag, ".wr_tag"}, 32'(write_tag_array), 32'd0);
  endtask

  // One IDLE cycle: optionally present a miss and/or a spurious return.
  task automatic idle_cycle(input string tag, input logic miss, input logic [15:0] addr,
                            input logic vld);
    @(negedge clk);
    miss_detected  = miss;
    miss_address   = addr;
    mem_data_valid = vld;
    mem_data_in    = 16'h5A5A;
    #1;
    chk_idle(tag);
  endtask

  // Cycles 1..last_c of a fill whose miss was presented in cycle 0.
  // Returns arrive on cycles 1+lat .. BW+lat carrying 0xA000+i.
  task automatic fill_cycles(input string tag, input logic [15:0] base, input int lat,
                             input int last_c, input bit toggle_miss);
    logic [15:0] exp_req;
    logic [15:0] exp_wr;
    logic [15:0] exp_dat;
    bit          vld;
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      vld            = (c >= 1 + lat) && (c <= BW + lat);
      exp_dat        = 16'hA000 + 16'(c - 1 - lat);
      miss_detected  = toggle_miss && c[0];
      miss_address   = 16'h7776;
      mem_data_valid = vld;
      mem_data_in    = vld ? exp_dat : 16'h0BAD;
      #1;
      chk($sformatf("%s.busy@%0d", tag, c), 32'(fsm_busy), 32'd1);
      chk($sformatf("%s.mem_en@%0d", tag, c), 32'(mem_en), 32'(c <= BW));
      if (c <= BW) begin
        exp_req = base + 16'(2 * (c - 1));
        chk($sformatf("%s.mem_addr@%0d", tag, c), 32'(mem_addr), 32'(exp_req));
      end
      chk($sformatf("%s.wr_data@%0d", tag, c), 32'(write_data_array), 32'(vld));
      if (vld) begin
        exp_wr = base + 16'(2 * (c - 1 - lat));
        chk($sformatf("%s.data_addr@%0d", tag, c), 32'(data_addr), 32'(exp_wr));
        chk($sformatf("%s.data_out@%0d", tag, c), 32'(data_out), 32'(exp_dat));
      end
      chk($sformatf("%s.wr_tag@%0d", tag, c), 32'(write_tag_array), 32'(c == BW + lat));
    end
  endtask

  initial begin
    rst            = 1'b1;
    miss_detected  = 1'b0;
    miss_address   = 16'h0;
    mem_data_valid = 1'b0;
    mem_data_in    = 16'h0;

    // Reset state, including a miss and a return presented while held in reset.
    @(negedge clk);
    miss_detected = 1'b1;
    mem_data_valid = 1'b1;
    #1;
    chk_idle("reset");
    chk("reset.mem_addr", 32'(mem_addr), 32'd0);
    chk("reset.data_addr", 32'(data_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    miss_detected = 1'b0;

    // Spurious returns in IDLE write nothing.
    idle_cycle("idle_vld0", 1'b0, 16'h0, 1'b1);
    idle_cycle("idle_vld1", 1'b0, 16'h0, 1'b1);

    // Fill 0x1236, L=4, with miss_detected toggling throughout the fill.
    idle_cycle("miss1", 1'b1, 16'h1236, 1'b0);
    fill_cycles("fill1", 16'h1230, 4, BW + 4, 1'b1);

    // Back-to-back: new miss on the cycle busy falls, L=2.
    idle_cycle("miss2", 1'b1, 16'h4000, 1'b0);
    fill_cycles("fill2", 16'h4000, 2, BW + 2, 1'b0);

    // Top-of-memory block, L=1: 0xFFF0..0xFFFE, 9 busy cycles.
    idle_cycle("miss3", 1'b1, 16'hFFFF, 1'b0);
    fill_cycles("fill3", 16'hFFF0, 1, BW + 1, 1'b0);
    idle_cycle("post3", 1'b0, 16'h0, 1'b0);

    // Reset after 3 words returned (L=2 -> words on cycles 3,4,5).
    idle_cycle("miss4", 1'b1, 16'h2000, 1'b0);
    fill_cycles("fill4", 16'h2000, 2, 5, 1'b0);
    @(negedge clk);
    miss_detected  = 1'b0;
    mem_data_valid = 1'b1;
    mem_data_in    = 16'hA003;
    rst            = 1'b1;
    #1;
    chk_idle("abort");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_idle("abort_rel");
    for (int i = 0; i < 6; i++) idle_cycle($sformatf("abort_late%0d", i), 1'b0, 16'h0, 1'b1);

    // Recovery after the abort.
    idle_cycle("miss5", 1'b1, 16'h0102, 1'b0);
    fill_cycles("fill5", 16'h0100, 1, BW + 1, 1'b0);
    idle_cycle("post5", 1'b0, 16'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
